// File: rtl/branch_predictor.sv
// Fetch-stage direct-mapped tagged BTB with 2-bit direction counters; zero-cycle lookup, one-cycle update visibility.
// No backpressure: one lookup and at most one resolution update are accepted every cycle.
module branch_predictor #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    output logic        PCSrcPredF,
    output logic [31:0] PredPCTargetF,
    output logic        HitF,
    input  logic        UpdateE,
    input  logic [31:0] PCE,
    input  logic        PCSrcResE,
    input  logic [31:0] PCTargetE,
    output logic [15:0] MispredCnt
);
    localparam int N = 1 << IDX_W;

    logic             r_valid  [N];
    logic [1:0]       r_ctr    [N];
    logic [TAG_W-1:0] r_tag    [N];
    logic [31:0]      r_target [N];
    logic [15:0]      r_mispred;

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic [1:0]       w_up_ctr;
    logic [31:0]      w_up_tgt;
    logic [1:0]       w_ctr_inc;
    logic [1:0]       w_ctr_dec;
    logic             w_up_pred;
    logic             w_mispred;
    logic [3:0]       w_unused_bits;

    assign w_unused_bits = {PCF[1:0], PCE[1:0]};

    // Lookup reads the stored entry only, so a same-cycle update is not visible yet.
    assign w_lk_idx      = PCF[IDX_W+1:2];
    assign w_lk_tag      = PCF[31:IDX_W+2];
    assign HitF          = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign PCSrcPredF    = HitF && r_ctr[w_lk_idx][1];
    assign PredPCTargetF = HitF ? r_target[w_lk_idx] : 32'h0;
    assign MispredCnt    = r_mispred;

    assign w_up_idx  = PCE[IDX_W+1:2];
    assign w_up_tag  = PCE[31:IDX_W+2];
    assign w_up_hit  = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_ctr  = r_ctr[w_up_idx];
    assign w_up_tgt  = r_target[w_up_idx];
    assign w_ctr_inc = (w_up_ctr == 2'b11) ? 2'b11 : w_up_ctr + 2'd1;
    assign w_ctr_dec = (w_up_ctr == 2'b00) ? 2'b00 : w_up_ctr - 2'd1;
    assign w_up_pred = w_up_hit && w_up_ctr[1];
    // A correct taken direction still counts as a miss when the stored target was stale.
    assign w_mispred = UpdateE && ((w_up_pred != PCSrcResE) ||
                       (w_up_pred && PCSrcResE && (w_up_tgt != PCTargetE)));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b01;
            end
            r_mispred <= 16'h0;
        end else if (UpdateE) begin
            if (w_up_hit) begin
                r_ctr[w_up_idx] <= PCSrcResE ? w_ctr_inc : w_ctr_dec;
            end else if (PCSrcResE) begin
                r_valid[w_up_idx] <= 1'b1;
                r_ctr[w_up_idx]   <= 2'b10;
            end
            if (w_mispred && (r_mispred != 16'hFFFF)) begin
                r_mispred <= r_mispred + 16'd1;
            end
        end
    end

    // Tag and target need no reset; they are only meaningful behind a valid bit.
    always_ff @(posedge clk) begin
        if (!reset && UpdateE && PCSrcResE) begin
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= PCTargetE;
        end
    end
endmodule
